// File: rtl/id_ex_register.sv
// -----------------------------------------------------------------------------
// id_ex_register
//   Pipeline register between the ID and EX stages of a MIPS-style core.
//   Each rising CLK edge applies exactly one update mode, highest priority
//   first:
//     flush  (Flush=1)                 : every EX output and EX_Valid -> 0
//     bubble (Flush=0, ControlSrc=0)   : controls -> 0, data/fields captured,
//                                        EX_Valid -> 0, bubble counter +1
//     normal (Flush=0, ControlSrc=1)   : everything captured, EX_Valid -> 1
//   All outputs are registered; Reset (active low) clears them asynchronously.
//
// Ports
//   CLK, Reset                     clock, async active-low reset
//   ControlSrc, Flush              hazard-unit / branch-resolution controls
//   ID_PC4/ReadData1/ReadData2/Imm32 (32)  -> EX_* (32)
//   ID_rs/rt/rd/sa (5)                     -> EX_* (5)
//   ID_RegWre/MemRead/MemWrite/ALUSrcA/ALUSrcB/DBDataSrc (1),
//   ID_RegDst (2), ID_ALUOp (3)            -> EX_* (same widths)
//   EX_Valid (1)                   1 = real instruction in EX
//   BubbleCount (16)               saturating count of bubbles since reset
//
// Configuration
//   ID_EX_BUBBLE_CNT_EN : when defined, BubbleCount is a live saturating
//   counter; otherwise the port is tied to 16'h0000 and no counter exists.
// -----------------------------------------------------------------------------
module id_ex_register (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        ControlSrc,
  input  logic        Flush,
  input  logic [31:0] ID_PC4,
  input  logic [31:0] ID_ReadData1,
  input  logic [31:0] ID_ReadData2,
  input  logic [31:0] ID_Imm32,
  input  logic [4:0]  ID_rs,
  input  logic [4:0]  ID_rt,
  input  logic [4:0]  ID_rd,
  input  logic [4:0]  ID_sa,
  input  logic        ID_RegWre,
  input  logic        ID_MemRead,
  input  logic        ID_MemWrite,
  input  logic        ID_ALUSrcA,
  input  logic        ID_ALUSrcB,
  input  logic        ID_DBDataSrc,
  input  logic [1:0]  ID_RegDst,
  input  logic [2:0]  ID_ALUOp,
  output logic [31:0] EX_PC4,
  output logic [31:0] EX_ReadData1,
  output logic [31:0] EX_ReadData2,
  output logic [31:0] EX_Imm32,
  output logic [4:0]  EX_rs,
  output logic [4:0]  EX_rt,
  output logic [4:0]  EX_rd,
  output logic [4:0]  EX_sa,
  output logic        EX_RegWre,
  output logic        EX_MemRead,
  output logic        EX_MemWrite,
  output logic        EX_ALUSrcA,
  output logic        EX_ALUSrcB,
  output logic        EX_DBDataSrc,
  output logic [1:0]  EX_RegDst,
  output logic [2:0]  EX_ALUOp,
  output logic        EX_Valid,
  output logic [15:0] BubbleCount
);

  logic flush_mode_s;
  logic bubble_mode_s;

  // Decode the single update mode for this edge (flush outranks bubble).
  always_comb begin
    flush_mode_s  = 1'b0;
    bubble_mode_s = 1'b0;
    if (Flush) begin
      flush_mode_s = 1'b1;
    end else if (!ControlSrc) begin
      bubble_mode_s = 1'b1;
    end else begin
      flush_mode_s  = 1'b0;
      bubble_mode_s = 1'b0;
    end
  end

  // Data and register-field payload: cleared only by flush, kept on bubble.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      EX_PC4       <= 32'h0000_0000;
      EX_ReadData1 <= 32'h0000_0000;
      EX_ReadData2 <= 32'h0000_0000;
      EX_Imm32     <= 32'h0000_0000;
      EX_rs        <= 5'd0;
      EX_rt        <= 5'd0;
      EX_rd        <= 5'd0;
      EX_sa        <= 5'd0;
    end else if (flush_mode_s) begin
      EX_PC4       <= 32'h0000_0000;
      EX_ReadData1 <= 32'h0000_0000;
      EX_ReadData2 <= 32'h0000_0000;
      EX_Imm32     <= 32'h0000_0000;
      EX_rs        <= 5'd0;
      EX_rt        <= 5'd0;
      EX_rd        <= 5'd0;
      EX_sa        <= 5'd0;
    end else begin
      EX_PC4       <= ID_PC4;
      EX_ReadData1 <= ID_ReadData1;
      EX_ReadData2 <= ID_ReadData2;
      EX_Imm32     <= ID_Imm32;
      EX_rs        <= ID_rs;
      EX_rt        <= ID_rt;
      EX_rd        <= ID_rd;
      EX_sa        <= ID_sa;
    end
  end

  // Control word and valid flag: zeroed by both flush and bubble, so a
  // stalled load never leaves EX_MemRead high for a second cycle.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      EX_RegWre    <= 1'b0;
      EX_MemRead   <= 1'b0;
      EX_MemWrite  <= 1'b0;
      EX_ALUSrcA   <= 1'b0;
      EX_ALUSrcB   <= 1'b0;
      EX_DBDataSrc <= 1'b0;
      EX_RegDst    <= 2'b00;
      EX_ALUOp     <= 3'b000;
      EX_Valid     <= 1'b0;
    end else if (flush_mode_s || bubble_mode_s) begin
      EX_RegWre    <= 1'b0;
      EX_MemRead   <= 1'b0;
      EX_MemWrite  <= 1'b0;
      EX_ALUSrcA   <= 1'b0;
      EX_ALUSrcB   <= 1'b0;
      EX_DBDataSrc <= 1'b0;
      EX_RegDst    <= 2'b00;
      EX_ALUOp     <= 3'b000;
      EX_Valid     <= 1'b0;
    end else begin
      EX_RegWre    <= ID_RegWre;
      EX_MemRead   <= ID_MemRead;
      EX_MemWrite  <= ID_MemWrite;
      EX_ALUSrcA   <= ID_ALUSrcA;
      EX_ALUSrcB   <= ID_ALUSrcB;
      EX_DBDataSrc <= ID_DBDataSrc;
      EX_RegDst    <= ID_RegDst;
      EX_ALUOp     <= ID_ALUOp;
      EX_Valid     <= 1'b1;
    end
  end

`ifdef ID_EX_BUBBLE_CNT_EN
  logic [15:0] bubble_cnt_r;

  // Saturating bubble counter; flush and normal edges leave it untouched.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      bubble_cnt_r <= 16'h0000;
    end else if (bubble_mode_s && (bubble_cnt_r != 16'hFFFF)) begin
      bubble_cnt_r <= bubble_cnt_r + 16'h0001;
    end else begin
      bubble_cnt_r <= bubble_cnt_r;
    end
  end

  assign BubbleCount = bubble_cnt_r;
`else
  assign BubbleCount = 16'h0000;
`endif

endmodule
